ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single BRAM data RAM between the instruction-fetch (I) and load/store (D) requesters.
//  - Arbitrates between the two, with round-robin fairness.
//  - Drives the RAM's read/write controls from registers, so the RAM's level-sensitive write path sees glitch-free inputs.
//  - Returns one in-order response per accepted request.
//  - Sits between the fetch/LSU stages and the RAM; it is the RAM's only master.
// PARAMETERS
//  BUS_WIDTH   8  address width (from params.svh); RAM depth = 1<<BUS_WIDTH
//  DATA_WIDTH  8  data word width (from params.svh)
// PORTS
//  clk            in   1           system clock; all state updates on posedge
//  rst            in   1           synchronous, active-high reset
//  i_req_valid    in   1           fetch request present (read only)
//  i_req_addr     in   BUS_WIDTH   fetch address
//  i_req_ready    out  1           fetch request accepted this cycle (combinational)
//  i_rsp_valid    out  1           fetch response valid (one-cycle pulse)
//  i_rsp_data     out  DATA_WIDTH  fetch read data
//  d_req_valid    in   1           load/store request present
//  d_req_we       in   1           1 = store, 0 = load
//  d_req_addr     in   BUS_WIDTH   load/store address
//  d_req_wdata    in   DATA_WIDTH  store data
//  d_req_ready    out  1           load/store request accepted this cycle (combinational)
//  d_rsp_valid    out  1           load data valid, or store acknowledge (pulse)
//  d_rsp_data     out  DATA_WIDTH  load data; 0 for a store acknowledge
//  ram_addr_rd    out  BUS_WIDTH   RAM read address (registered)
//  ram_addr_wr    out  BUS_WIDTH   RAM write address (registered; same register as ram_addr_rd)
//  ram_data_wr    out  DATA_WIDTH  RAM write data (registered)
//  ram_rd_en      out  1           RAM read enable (registered)
//  ram_wr_en      out  1           RAM write enable (registered)
//  ram_data_rd    in   DATA_WIDTH  RAM read data; valid the cycle after ram_rd_en
// BEHAVIOUR
//  Reset
//  - All outputs 0; rr_ptr = D (I wins the first contention); pipeline valid bits cleared.
//  - While rst is high, no request is accepted.
//  Acceptance (cycle G)
//  - At most one request is accepted per cycle; a requester must hold valid and its fields until ready.
//  - Exactly one valid: that one is accepted.
//  - Both valid: the requester that is NOT rr_ptr wins; rr_ptr <= winner.
//  - Neither valid: rr_ptr holds.
//  Stage 1 (cycle G+1, registered controls)
//  - ram_addr_* <= addr; ram_data_wr <= wdata (D store), else hold.
//  - Read: ram_rd_en = 1 for exactly one cycle.
//  - Write: ram_wr_en = 1 for exactly one cycle; the RAM write completes in G+1.
//  - rd_en and wr_en are never both 1: only one accept per cycle.
//  Stage 2 (cycle G+2, response)
//  - <x>_rsp_valid pulses for one cycle, tagged by the requester ID carried through the pipe.
//  - Read: rsp_data = ram_data_rd.
//  - Store: rsp_valid pulses with d_rsp_data = 0.
//  - The non-selected rsp_data stays 0.
//  Throughput and ordering
//  - Fixed latency of 2 cycles for every request.
//  - One request per cycle, fully pipelined; responses are in acceptance order.
//  - A read accepted at G+1 after a store at G to the same address returns the new data, because the write lands in G+1 and the read's rd_en is asserted in G+2.
//  Reset mid-operation
//  - Registers clear on the rst edge and in-flight responses are dropped (no rsp_valid).
//  - A write whose wr_en cycle had already begun is completed in the RAM.
//  Width
//  - Addresses and data are passed through unmodified; no arithmetic, no wrap logic.
// STRUCTURE
//  - params.svh gains: typedef enum logic {REQ_I=1'b0, REQ_D=1'b1} req_id_t; typedef enum {OP_RD, OP_WR} ram_op_t.
//  - Sub-module rr_arb2: 2-input round-robin grant with rr_ptr register; ports clk, rst, req[1:0], gnt[1:0].
//  - Top level: request mux, stage-1 control registers, stage-2 {valid, id, op} register, response demux.
// TESTING
//  1. Reset: rst=1 for 2 cycles with both valid=1 -> all outputs 0, no ready.
//     After release: I accepted first, D next cycle.
//  2. Single read: preload mem[0x10]=0xA5; I valid, addr=0x10 at G -> i_req_ready at G; ram_rd_en at G+1;
//     i_rsp_valid at G+2 with data 0xA5.
//  3. Store then load: D store 0x3C to 0x22 at G, D load 0x22 at G+1 -> ram_wr_en only at G+1;
//     ack at G+2 (data 0); load rsp at G+3 with data 0x3C.
//  4. Contention: I and D valid for 6 cycles -> grants alternate I,D,I,D,I,D.
//     ram_rd_en & ram_wr_en never both 1 (assertion held throughout).
//  5. Back-to-back: I reads 0x00..0x07 on consecutive cycles -> 8 consecutive i_rsp_valid, in order.
//  6. Reset mid-flight: rst at G+1 after a D load accepted at G -> no d_rsp_valid at G+2; all outputs 0 at G+2.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared widths and types for the RAM port arbiter slice.
//   BUS_WIDTH  : RAM address width (depth = 1 << BUS_WIDTH)
//   DATA_WIDTH : RAM data word width
//   req_id_t   : requester identity carried through the pipeline
//   ram_op_t   : RAM operation carried through the pipeline
package ram_port_arbiter_pkg;

  localparam int BUS_WIDTH  = 8;
  localparam int DATA_WIDTH = 8;

  typedef logic [BUS_WIDTH-1:0]  addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Encodings double as bit positions in the req/gnt vectors.
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} ram_op_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bundles the fetch (I) request/response, load/store (D) request/response
//   and RAM control signals of the arbiter.
//   modport slave  : the arbiter's view (takes requests, drives the RAM)
//   modport master : the surrounding environment's view (fetch, LSU, RAM)
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  // fetch port
  logic  i_req_valid;
  addr_t i_req_addr;
  logic  i_req_ready;
  logic  i_rsp_valid;
  data_t i_rsp_data;

  // load/store port
  logic  d_req_valid;
  logic  d_req_we;
  addr_t d_req_addr;
  data_t d_req_wdata;
  logic  d_req_ready;
  logic  d_rsp_valid;
  data_t d_rsp_data;

  // RAM side
  addr_t ram_addr_rd;
  addr_t ram_addr_wr;
  data_t ram_data_wr;
  logic  ram_rd_en;
  logic  ram_wr_en;
  data_t ram_data_rd;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output ram_addr_rd, ram_addr_wr, ram_data_wr, ram_rd_en, ram_wr_en,
    input  ram_data_rd
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  ram_addr_rd, ram_addr_wr, ram_data_wr, ram_rd_en, ram_wr_en,
    output ram_data_rd
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2
//   Two-input round-robin arbiter. On contention the requester that did not
//   win the previous contention is granted. Grants are combinational and
//   suppressed while rst is high.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request vector (bit 0 = fetch, bit 1 = load/store)
//   gnt[1:0] : one-hot (or zero) grant vector, same bit order
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Points at the last contention winner; reset to D so I wins first.
  req_id_t rr_ptr_reg;
  req_id_t rr_ptr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= REQ_D;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    gnt         = 2'b00;
    rr_ptr_next = rr_ptr_reg;
    if (!rst) begin
      unique case (req)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          // The pointer only moves when both compete.
          if (rr_ptr_reg == REQ_D) begin
            gnt         = 2'b01;
            rr_ptr_next = REQ_I;
          end else begin
            gnt         = 2'b10;
            rr_ptr_next = REQ_D;
          end
        end
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Sole master of the shared data RAM. Arbitrates fetch (I, read only) and
//   load/store (D) requests round-robin, drives the RAM controls from
//   registers and returns one in-order response per accepted request with a
//   fixed two-cycle latency.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : request/response handshakes and RAM controls (slave modport)
//
//   Pipeline: G  = accept (combinational ready)
//             G+1 = registered RAM controls (rd_en / wr_en one-cycle pulse)
//             G+2 = response, read data straight from the RAM output
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  bus
);

  // ---------------- arbitration ----------------
  logic [1:0] req;
  logic [1:0] gnt;

  assign req = {bus.d_req_valid, bus.i_req_valid};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.i_req_ready = gnt[0];
  assign bus.d_req_ready = gnt[1];

  // ---------------- request mux ----------------
  logic    sel_valid;
  req_id_t sel_id;
  ram_op_t sel_op;
  addr_t   sel_addr;

  assign sel_valid = |gnt;
  assign sel_id    = gnt[1] ? REQ_D : REQ_I;
  assign sel_op    = (gnt[1] && bus.d_req_we) ? OP_WR : OP_RD;
  assign sel_addr  = gnt[1] ? bus.d_req_addr : bus.i_req_addr;

  // ---------------- stage 1: RAM controls ----------------
  addr_t   ram_addr_reg;
  data_t   ram_data_wr_reg;
  logic    ram_rd_en_reg;
  logic    ram_wr_en_reg;
  req_id_t s1_id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_reg    <= '0;
      ram_data_wr_reg <= '0;
      ram_rd_en_reg   <= 1'b0;
      ram_wr_en_reg   <= 1'b0;
      s1_id_reg       <= REQ_I;
    end else begin
      // Enables are rebuilt every cycle, so each lasts exactly one cycle.
      ram_rd_en_reg <= sel_valid && (sel_op == OP_RD);
      ram_wr_en_reg <= sel_valid && (sel_op == OP_WR);
      // Address/data hold when idle so the RAM inputs never toggle needlessly.
      if (sel_valid) begin
        ram_addr_reg <= sel_addr;
        s1_id_reg    <= sel_id;
      end
      if (sel_valid && (sel_op == OP_WR)) begin
        ram_data_wr_reg <= bus.d_req_wdata;
      end
    end
  end

  assign bus.ram_addr_rd = ram_addr_reg;
  assign bus.ram_addr_wr = ram_addr_reg;
  assign bus.ram_data_wr = ram_data_wr_reg;
  assign bus.ram_rd_en   = ram_rd_en_reg;
  assign bus.ram_wr_en   = ram_wr_en_reg;

  // ---------------- stage 2: response tag ----------------
  logic    s2_valid_reg;
  req_id_t s2_id_reg;
  ram_op_t s2_op_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Dropping the tag discards any in-flight response.
      s2_valid_reg <= 1'b0;
      s2_id_reg    <= REQ_I;
      s2_op_reg    <= OP_RD;
    end else begin
      s2_valid_reg <= ram_rd_en_reg || ram_wr_en_reg;
      s2_id_reg    <= s1_id_reg;
      s2_op_reg    <= ram_wr_en_reg ? OP_WR : OP_RD;
    end
  end

  // ---------------- response demux ----------------
  logic [1:0] s2_hit;
  logic       rsp_valid_w [2];
  data_t      rsp_data_w  [2];

  assign s2_hit = !s2_valid_reg       ? 2'b00 :
                  (s2_id_reg == REQ_D) ? 2'b10 : 2'b01;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid_w[gi] = s2_hit[gi];
      // Store acks and the non-selected port return zero data.
      assign rsp_data_w[gi]  = (s2_hit[gi] && (s2_op_reg == OP_RD)) ?
                               bus.ram_data_rd : '0;
    end
  endgenerate

  assign bus.i_rsp_valid = rsp_valid_w[0];
  assign bus.i_rsp_data  = rsp_data_w[0];
  assign bus.d_rsp_valid = rsp_valid_w[1];
  assign bus.d_rsp_data  = rsp_data_w[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Self-checking bench: a cycle table for single read, store-then-load and
//   back-to-back reads, plus hand-written reset, contention and
//   reset-mid-flight sequences. A behavioural RAM with registered read sits
//   on the RAM side.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM model with bench preload port ----------------
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  always @(posedge clk) begin
    if (pre_we)             mem[pre_addr] <= pre_data;
    else if (bus.ram_wr_en) mem[bus.ram_addr_wr] <= bus.ram_data_wr;
    if (bus.ram_rd_en)      bus.ram_data_rd <= mem[bus.ram_addr_rd];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (bus.ram_rd_en === 1'b1 && bus.ram_wr_en === 1'b1) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       iv;   logic [7:0] ia;
    logic       dv;   logic       dwe;  logic [7:0] da;  logic [7:0] dwd;
    logic       e_ir; logic       e_dr; logic       e_rd; logic       e_wr;
    logic [7:0] e_addr; logic [7:0] e_wd;
    logic       e_iv; logic [7:0] e_id;
    logic       e_dv; logic [7:0] e_dd;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic iv, input logic [7:0] ia,
    input logic dv, input logic dwe, input logic [7:0] da, input logic [7:0] dwd,
    input logic e_ir, input logic e_dr, input logic e_rd, input logic e_wr,
    input logic [7:0] e_addr, input logic [7:0] e_wd,
    input logic e_iv, input logic [7:0] e_id, input logic e_dv, input logic [7:0] e_dd);
    vec_t v;
    v = '{iv, ia, dv, dwe, da, dwd, e_ir, e_dr, e_rd, e_wr, e_addr, e_wd, e_iv, e_id, e_dv, e_dd};
    return v;
  endfunction

  task automatic drive_idle();
    bus.i_req_valid = 1'b0; bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0; bus.d_req_we    = 1'b0;
    bus.d_req_addr  = '0;   bus.d_req_wdata = '0;
  endtask

  // Leaves the bench #1 after a posedge with rst low.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ram_rd_en"},   bus.ram_rd_en,   0);
    check({tag, " ram_wr_en"},   bus.ram_wr_en,   0);
    check({tag, " ram_addr_rd"}, bus.ram_addr_rd, 0);
    check({tag, " ram_data_wr"}, bus.ram_data_wr, 0);
    check({tag, " i_rsp_valid"}, bus.i_rsp_valid, 0);
    check({tag, " d_rsp_valid"}, bus.d_rsp_valid, 0);
    check({tag, " i_rsp_data"},  bus.i_rsp_data,  0);
    check({tag, " d_rsp_data"},  bus.d_rsp_data,  0);
  endtask

  initial begin
    // Cycle script (row k = inputs and expected outputs in cycle k after reset).
    //                 iv ia     dv we da     dwd    ir dr rd wr addr   wd     iv id     dv dd
    vecs[0]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[2]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[3]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h10, 8'h00, 1, 8'hA5, 0, 8'h00);
    vecs[4]  = mk(0, 8'h00, 1, 1, 8'h22, 8'h3C, 0, 1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00);
    vecs[5]  = mk(0, 8'h00, 1, 0, 8'h22, 8'h00, 0, 1, 0, 1, 8'h22, 8'h3C, 0, 8'h00, 0, 8'h00);
    vecs[6]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h22, 8'h3C, 0, 8'h00, 1, 8'h00);
    vecs[7]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h22, 8'h3C, 0, 8'h00, 1, 8'h3C);
    vecs[8]  = mk(1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h22, 8'h3C, 0, 8'h00, 0, 8'h00);
    vecs[9]  = mk(1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h3C, 0, 8'h00, 0, 8'h00);
    vecs[10] = mk(1, 8'h02, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h01, 8'h3C, 1, 8'h80, 0, 8'h00);
    vecs[11] = mk(1, 8'h03, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h02, 8'h3C, 1, 8'h81, 0, 8'h00);
    vecs[12] = mk(1, 8'h04, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h03, 8'h3C, 1, 8'h82, 0, 8'h00);
    vecs[13] = mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h04, 8'h3C, 1, 8'h83, 0, 8'h00);
    vecs[14] = mk(1, 8'h06, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h05, 8'h3C, 1, 8'h84, 0, 8'h00);
    vecs[15] = mk(1, 8'h07, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h06, 8'h3C, 1, 8'h85, 0, 8'h00);
    vecs[16] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h07, 8'h3C, 1, 8'h86, 0, 8'h00);
    vecs[17] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h07, 8'h3C, 1, 8'h87, 0, 8'h00);
    vecs[18] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h07, 8'h3C, 0, 8'h00, 0, 8'h00);

    drive_idle();

    // ---- preload RAM while held in reset ----
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      pre_we   = 1'b1;
      pre_addr = (k < 8) ? 8'(k) : ((k == 8) ? 8'h10 : 8'h22);
      pre_data = (k < 8) ? 8'(8'h80 + k) : ((k == 8) ? 8'hA5 : 8'h11);
    end
    @(posedge clk); #1 pre_we = 1'b0;

    // ---- reset with both requesters valid ----
    bus.i_req_valid = 1'b1; bus.i_req_addr = 8'h10;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 8'h22;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst%0d i_req_ready", k), bus.i_req_ready, 0);
      check($sformatf("rst%0d d_req_ready", k), bus.d_req_ready, 0);
      @(posedge clk); #1;
    end
    check_all_zero("rst");
    $display("reset: held 2 cycles with both valid");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst first i_req_ready", bus.i_req_ready, 1);
    check("post_rst first d_req_ready", bus.d_req_ready, 0);
    $display("post-reset cycle 0: i_ready=%0b d_ready=%0b", bus.i_req_ready, bus.d_req_ready);
    @(posedge clk); #1 bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("post_rst second d_req_ready", bus.d_req_ready, 1);
    check("post_rst second i_req_ready", bus.i_req_ready, 0);
    $display("post-reset cycle 1: i_ready=%0b d_ready=%0b", bus.i_req_ready, bus.d_req_ready);

    // ---- table-driven cycle script ----
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      bus.i_req_valid = vecs[i].iv;  bus.i_req_addr  = vecs[i].ia;
      bus.d_req_valid = vecs[i].dv;  bus.d_req_we    = vecs[i].dwe;
      bus.d_req_addr  = vecs[i].da;  bus.d_req_wdata = vecs[i].dwd;
      @(negedge clk);
      check($sformatf("row%0d i_req_ready", i), bus.i_req_ready, vecs[i].e_ir);
      check($sformatf("row%0d d_req_ready", i), bus.d_req_ready, vecs[i].e_dr);
      check($sformatf("row%0d ram_rd_en", i),   bus.ram_rd_en,   vecs[i].e_rd);
      check($sformatf("row%0d ram_wr_en", i),   bus.ram_wr_en,   vecs[i].e_wr);
      check($sformatf("row%0d ram_addr_rd", i), bus.ram_addr_rd, vecs[i].e_addr);
      check($sformatf("row%0d ram_addr_wr", i), bus.ram_addr_wr, vecs[i].e_addr);
      check($sformatf("row%0d ram_data_wr", i), bus.ram_data_wr, vecs[i].e_wd);
      check($sformatf("row%0d i_rsp_valid", i), bus.i_rsp_valid, vecs[i].e_iv);
      check($sformatf("row%0d i_rsp_data", i),  bus.i_rsp_data,  vecs[i].e_id);
      check($sformatf("row%0d d_rsp_valid", i), bus.d_rsp_valid, vecs[i].e_dv);
      check($sformatf("row%0d d_rsp_data", i),  bus.d_rsp_data,  vecs[i].e_dd);
      $display("row %0d: rd=%0b wr=%0b addr=%02h irsp=%0b/%02h drsp=%0b/%02h",
               i, bus.ram_rd_en, bus.ram_wr_en, bus.ram_addr_rd,
               bus.i_rsp_valid, bus.i_rsp_data, bus.d_rsp_valid, bus.d_rsp_data);
      @(posedge clk); #1;
    end

    // ---- contention: both valid for 6 grants, expect I,D,I,D,I,D ----
    do_reset();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 8'h10;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 8'h22;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("contend%0d i_req_ready", k), bus.i_req_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("contend%0d d_req_ready", k), bus.d_req_ready, (k % 2 == 1) ? 1 : 0);
      $display("contend %0d: i_ready=%0b d_ready=%0b", k, bus.i_req_ready, bus.d_req_ready);
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (3) @(posedge clk);
    #1;

    // ---- reset mid-flight: D load accepted at G, rst during G+1 ----
    do_reset();
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 8'h22;
    @(negedge clk);
    check("midrst G d_req_ready", bus.d_req_ready, 1);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst G+1 ram_rd_en", bus.ram_rd_en, 1);
    check("midrst G+1 d_req_ready", bus.d_req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst G+2");
    $display("reset mid-flight: d_rsp_valid=%0b at G+2", bus.d_rsp_valid);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst G+3 d_rsp_valid", bus.d_rsp_valid, 0);

    check("rd_wr_overlap count", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
